// File: rtl/sram_mbist_pkg.sv
// Shared types for the March C- BIST: FSM state encoding and the per-element descriptor table.
package sram_mbist_pkg;

    localparam int NUM_ELEM = 6;

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_e;

    typedef struct packed {
        logic down;
        logic rd_val;
        logic wr_val;
        logic has_rd;
        logic has_wr;
    } elem_t;

    // Fields: down, rd_val, wr_val, has_rd, has_wr
    localparam elem_t ELEM_TBL [0:NUM_ELEM-1] = '{
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},   // M0 up(w0)
        '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1},   // M1 up(r0,w1)
        '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},   // M2 up(r1,w0)
        '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1},   // M3 down(r0,w1)
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},   // M4 down(r1,w0)
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0}    // M5 up(r0)
    };

    function automatic logic [2:0] elem_idx(input state_e s);
        case (s)
            S_M1:    return 3'd1;
            S_M2:    return 3'd2;
            S_M3:    return 3'd3;
            S_M4:    return 3'd4;
            S_M5:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic in_march(input state_e s);
        return (s inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5});
    endfunction

endpackage

// File: rtl/sram_mbist_addr_gen.sv
// Loadable up/down address counter; direction is latched on load, tc_o flags the last address.
module sram_mbist_addr_gen
    import sram_mbist_pkg::*;
#(
    parameter int              ADDR_W = 10,
    parameter logic [ADDR_W-1:0] LAST = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              down_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);
    logic [ADDR_W-1:0] cnt_q;
    logic              dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dir_q <= 1'b0;
        end else if (load_i) begin
            dir_q <= down_i;
            cnt_q <= down_i ? LAST : '0;
        end else if (en_i) begin
            cnt_q <= dir_q ? cnt_q - ADDR_W'(1) : cnt_q + ADDR_W'(1);
        end
    end

    assign addr_o = cnt_q;
    assign tc_o   = dir_q ? (cnt_q == '0) : (cnt_q == LAST);

endmodule

// File: rtl/sram_mbist.sv
// March C- BIST initiator for one sram1024x18 port.
// Define SRAM_MBIST_FAIL_LOG_EN to build the first-fail capture registers behind fail_*.
module sram_mbist
    import sram_mbist_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 18,
    parameter int DEPTH    = 1024,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic                cen,
    output logic                wen,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wmsk,
    output logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [DATA_W-1:0]   fail_exp,
    output logic [DATA_W-1:0]   fail_act,
    output logic [2:0]          fail_elem
);
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

    state_e              state_q;
    logic                phase_q, drain_q, cen_q, wen_q, busy_q, done_q, pass_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [2:0]          cur_idx, nxt_idx;
    logic                start_acc, last_op, cnt_load, cnt_en, cnt_down, cnt_tc;
    logic                op_go, op_wr, op_val, miscmp;
    logic [ADDR_W-1:0]   addr_w;
    logic                vld_p0_q, vld_p1_q;
    logic [DATA_W-1:0]   exp_p0_q, exp_p1_q, rdata_p1_q;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + ERRCNT_W'(1);
    endfunction

    // state_q/addr describe the op on the pins now; op_* describe the one issued at the next edge
    always_comb begin
        cur_idx   = elem_idx(state_q);
        nxt_idx   = (cur_idx == LAST_ELEM) ? cur_idx : cur_idx + 3'd1;
        start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
        last_op   = in_march(state_q) &&
                    !(ELEM_TBL[cur_idx].has_rd && ELEM_TBL[cur_idx].has_wr && !phase_q);
        cnt_load  = start_acc || (last_op && cnt_tc && cur_idx != LAST_ELEM);
        cnt_en    = last_op && !cnt_tc;
        cnt_down  = start_acc ? ELEM_TBL[0].down : ELEM_TBL[nxt_idx].down;
        op_go     = 1'b0;
        op_wr     = 1'b0;
        op_val    = 1'b0;
        if (start_acc) begin
            op_go  = 1'b1;
            op_wr  = !ELEM_TBL[0].has_rd;
            op_val = ELEM_TBL[0].wr_val;
        end else if (in_march(state_q)) begin
            if (!last_op) begin
                op_go  = 1'b1;
                op_wr  = 1'b1;
                op_val = ELEM_TBL[cur_idx].wr_val;
            end else if (!cnt_tc) begin
                op_go  = 1'b1;
                op_wr  = !ELEM_TBL[cur_idx].has_rd;
                op_val = ELEM_TBL[cur_idx].wr_val;
            end else if (cur_idx != LAST_ELEM) begin
                op_go  = 1'b1;
                op_wr  = !ELEM_TBL[nxt_idx].has_rd;
                op_val = ELEM_TBL[nxt_idx].wr_val;
            end
        end
        miscmp    = vld_p1_q && (rdata_p1_q != exp_p1_q);
        err_cnt_d = err_cnt_q;
        if (start_acc) begin
            err_cnt_d = '0;
        end else if (miscmp) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    sram_mbist_addr_gen #(
        .ADDR_W (ADDR_W),
        .LAST   (ADDR_W'(DEPTH - 1))
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .down_i (cnt_down),
        .en_i   (cnt_en),
        .addr_o (addr_w),
        .tc_o   (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            drain_q <= 1'b0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            cen_q <= !op_go;
            wen_q <= !(op_go && op_wr);
            if (op_go && op_wr) begin
                wdata_q <= {DATA_W{op_val}};
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_M0;
                        phase_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                    if (ELEM_TBL[cur_idx].has_rd && ELEM_TBL[cur_idx].has_wr) begin
                        phase_q <= !phase_q;
                    end
                    if (last_op && cnt_tc) begin
                        state_q <= (cur_idx == LAST_ELEM) ? S_DRAIN : state_e'(state_q + 4'd1);
                        drain_q <= 1'b0;
                    end
                end
                // The last read's compare lands together with the DONE transition
                S_DRAIN: begin
                    if (drain_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Compare pipeline: p0 = SRAM latches the read, p1 = rdata captured, then error update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            vld_p0_q  <= !cen_q && wen_q;
            vld_p1_q  <= vld_p0_q;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        exp_p0_q   <= {DATA_W{ELEM_TBL[cur_idx].rd_val}};
        exp_p1_q   <= exp_p0_q;
        rdata_p1_q <= rdata;
    end

`ifdef SRAM_MBIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] addr_p0_q, addr_p1_q, fail_addr_q;
    logic [2:0]        elem_p0_q, elem_p1_q, fail_elem_q;
    logic [DATA_W-1:0] fail_exp_q, fail_act_q;

    always_ff @(posedge clk) begin
        addr_p0_q <= addr_w;
        elem_p0_q <= cur_idx;
        addr_p1_q <= addr_p0_q;
        elem_p1_q <= elem_p0_q;
    end

    // err_cnt never returns to zero within a run, so zero marks "no fail captured yet"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            fail_elem_q <= '0;
        end else if (start_acc) begin
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            fail_elem_q <= '0;
        end else if (miscmp && err_cnt_q == '0) begin
            fail_addr_q <= addr_p1_q;
            fail_exp_q  <= exp_p1_q;
            fail_act_q  <= rdata_p1_q;
            fail_elem_q <= elem_p1_q;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;
    assign fail_elem = fail_elem_q;
`else
    assign fail_addr = '0;
    assign fail_exp  = '0;
    assign fail_act  = '0;
    assign fail_elem = '0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;
    assign cen     = cen_q;
    assign wen     = wen_q;
    assign addr    = addr_w;
    assign wmsk    = '0;
    assign wdata   = wdata_q;

endmodule

// File: tb/tb_sram_mbist.sv
// Bench for sram_mbist: behavioural 1024x18 port with stuck-at injection, op-stream monitor and result scoreboard.
module tb_sram_mbist;
    localparam int AW = 10;
    localparam int DW = 18;
    localparam int EW = 8;
`ifdef SRAM_MBIST_FAIL_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic          busy, done, pass, cen, wen;
    logic [EW-1:0] err_cnt;
    logic [AW-1:0] addr, fail_addr;
    logic [DW-1:0] wmsk, wdata, fail_exp, fail_act;
    logic [DW-1:0] rdata = '0;
    logic [2:0]    fail_elem;

    sram_mbist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(1024), .ERRCNT_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .cen(cen), .wen(wen), .addr(addr), .wmsk(wmsk), .wdata(wdata),
        .rdata(rdata), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
        .fail_elem(fail_elem)
    );

    always #5 clk = ~clk;

    // SRAM port a model; sa1/sa0 force bits high/low on read
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] sa1 [0:1023];
    logic [DW-1:0] sa0 [0:1023];

    always @(posedge clk) begin
        if (!cen) begin
            if (!wen) mem[addr] <= (wdata & ~wmsk) | (mem[addr] & wmsk);
            else      rdata     <= (mem[addr] | sa1[addr]) & ~sa0[addr];
        end
    end

    function automatic void exp_op(input int k, output logic w, output logic [AW-1:0] a,
                                   output logic [DW-1:0] d);
        int e, j, i;
        d = '0;
        if (k < 1024) begin
            w = 1'b1; a = AW'(k);
        end else if (k >= 9216) begin
            w = 1'b0; a = AW'(k - 9216);
        end else begin
            e = (k - 1024) / 2048 + 1;
            j = (k - 1024) % 2048;
            i = j / 2;
            w = (j % 2 == 1);
            a = (e >= 3) ? AW'(1023 - i) : AW'(i);
            d = (e == 1 || e == 3) ? '1 : '0;
        end
    endfunction

    int run_id = 0;
    int seen_id = 0;
    int op_k = 0;
    int op_err = 0;
    int wr_viol = 0;

    always @(negedge clk) begin
        logic ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (run_id != seen_id) begin
            seen_id = run_id; op_k = 0; op_err = 0; wr_viol = 0;
        end
        if (!wen && (cen || wmsk != '0)) wr_viol++;
        if (!cen) begin
            exp_op(op_k, ew, ea, ed);
            if (wen !== !ew || addr !== ea || (ew && wdata !== ed)) op_err++;
            op_k++;
        end
    end

    typedef struct {
        logic          pass;
        logic [EW-1:0] err;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fexp;
        logic [DW-1:0] fact;
        logic [2:0]    felem;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk_exp(input logic p, input int err, input int fa, input int fe,
                                    input int fx, input int el);
        exp_t e;
        e.pass  = p;
        e.err   = EW'(err);
        e.faddr = LOG_EN ? AW'(fa) : '0;
        e.fexp  = LOG_EN ? DW'(fe) : '0;
        e.fact  = LOG_EN ? DW'(fx) : '0;
        e.felem = LOG_EN ? 3'(el) : '0;
        return e;
    endfunction

    task automatic run_check(input string name, input exp_t e, input bit poke);
        int   cyc;
        exp_t g;
        @(negedge clk);
        start = 1'b1;
        run_id++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        check({name, "_busy_at_start"}, 32'(busy), 32'(1));
        check({name, "_done_at_start"}, 32'(done), 32'(0));
        check({name, "_cen_op0"}, 32'(cen), 32'(0));
        while (done !== 1'b1 && cyc < 12000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (poke && (cyc == 3000 || cyc == 7000));
        end
        start = 1'b0;
        g = sb.pop_front();
        check({name, "_done_cycles"}, 32'(cyc), 32'(10242));
        check({name, "_busy_end"}, 32'(busy), 32'(0));
        check({name, "_cen_end"}, 32'(cen), 32'(1));
        check({name, "_pass"}, 32'(pass), 32'(g.pass));
        check({name, "_err_cnt"}, 32'(err_cnt), 32'(g.err));
        check({name, "_fail_addr"}, 32'(fail_addr), 32'(g.faddr));
        check({name, "_fail_exp"}, 32'(fail_exp), 32'(g.fexp));
        check({name, "_fail_act"}, 32'(fail_act), 32'(g.fact));
        check({name, "_fail_elem"}, 32'(fail_elem), 32'(g.felem));
        check({name, "_op_count"}, 32'(op_k), 32'(10240));
        check({name, "_op_stream"}, 32'(op_err), 32'(0));
        check({name, "_write_protocol"}, 32'(wr_viol), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
        rst_n = 1'b0;
        #12;
        check("rst_cen", 32'(cen), 32'(1));
        check("rst_wen", 32'(wen), 32'(1));
        check("rst_addr", 32'(addr), 32'(0));
        check("rst_wmsk", 32'(wmsk), 32'(0));
        check("rst_wdata", 32'(wdata), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_pass", 32'(pass), 32'(0));
        check("rst_err_cnt", 32'(err_cnt), 32'(0));
        check("rst_fail_addr", 32'(fail_addr), 32'(0));
        check("rst_fail_elem", 32'(fail_elem), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_check("clean", mk_exp(1'b1, 0, 0, 0, 0, 0), 1'b1);

        sa1[10'h155] = 18'h00008;
        run_check("sa1", mk_exp(1'b0, 3, 'h155, 'h0, 'h00008, 1), 1'b0);
        sa1[10'h155] = '0;

        sa0[10'h3FF] = 18'h20000;
        run_check("sa0", mk_exp(1'b0, 2, 'h3FF, 'h3FFFF, 'h1FFFF, 2), 1'b0);
        sa0[10'h3FF] = '0;

        for (int i = 0; i < 100; i++) sa1[i] = '1;
        run_check("sat", mk_exp(1'b0, 255, 'h0, 'h0, 'h3FFFF, 1), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("sat_err_hold", 32'(err_cnt), 32'(255));
        check("sat_done_hold", 32'(done), 32'(1));
        for (int i = 0; i < 100; i++) sa1[i] = '0;

        @(negedge clk);
        start = 1'b1;
        run_id++;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5000) @(posedge clk);
        #1;
        check("mid_busy_before_rst", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_cen", 32'(cen), 32'(1));
        check("mid_rst_wen", 32'(wen), 32'(1));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_addr", 32'(addr), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_check("after_rst", mk_exp(1'b1, 0, 0, 0, 0, 0), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
